// File: rtl/instr_encode_writer.sv
// Packs RV32I instruction fields into a 32-bit word, checks immediate legality,
// and streams legal words into an instruction-memory write port.
module instr_encode_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              full
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  ptr, ptr_next;
  logic [CNT_W-1:0]   count_next;
  logic               we_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [31:0]        wdata_next;
  logic               errv_next;
  logic [1:0]         errc_next;

  logic [31:0]        enc_word;
  logic [1:0]         enc_err;
  logic               accept;

  // Sign-extension tests: upper immediate bits must all match the sign bit
  logic fits_11, fits_12, fits_20;
  assign fits_11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  assign in_ready = (state == ST_ACTIVE) && !start;
  assign accept   = in_valid && in_ready;

  // Field packing and legality; misalignment outranks range
  always_comb begin
    enc_word = 32'd0;
    enc_err  = ERR_NONE;
    case (in_fmt)
      FMT_R: begin
        enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      end
      FMT_I: begin
        enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
        if (!fits_11) enc_err = ERR_RANGE;
      end
      FMT_S: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
        if (!fits_11) enc_err = ERR_RANGE;
      end
      FMT_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0])     enc_err = ERR_ALIGN;
        else if (!fits_12) enc_err = ERR_RANGE;
      end
      FMT_U: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        if (|in_imm[11:0]) enc_err = ERR_ALIGN;
      end
      FMT_J: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])     enc_err = ERR_ALIGN;
        else if (!fits_20) enc_err = ERR_RANGE;
      end
      default: enc_err = ERR_FMT;
    endcase
  end

  // Next-state and next-output logic; start overrides any accept
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    count_next = word_count;
    we_next    = 1'b0;
    addr_next  = imem_addr;
    wdata_next = imem_wdata;
    errv_next  = 1'b0;
    errc_next  = err_code;

    if (start) begin
      state_next = ST_ACTIVE;
      ptr_next   = '0;
      count_next = '0;
    end else if (accept) begin
      if (enc_err == ERR_NONE) begin
        we_next    = 1'b1;
        addr_next  = ptr;
        wdata_next = enc_word;
        count_next = word_count + CNT_W'(1);
        if (count_next == CNT_W'(DEPTH)) begin
          state_next = ST_FULL;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + ADDR_W'(1);
        end
      end else begin
        errv_next = 1'b1;
        errc_next = enc_err;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      full       <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      word_count <= count_next;
      imem_we    <= we_next;
      imem_addr  <= addr_next;
      imem_wdata <= wdata_next;
      err_valid  <= errv_next;
      err_code   <= errc_next;
      full       <= (state_next == ST_FULL);
    end
  end

endmodule

// File: tb/tb_instr_encode_writer.sv
// Self-checking bench for instr_encode_writer: directed plan steps followed by
// random bundles checked against an arithmetic reference of the encoding rules.
module tb_instr_encode_writer;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_func3;
  logic [6:0]        in_func7;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;
  logic              full;

  int errors = 0;
  int checks = 0;

  // Reference state: 0 idle, 1 active, 2 full
  int          m_state;
  int          m_ptr;
  int          m_cnt;
  logic        m_we;
  int          m_addr;
  logic [31:0] m_wdata;
  logic        m_errv;
  int          m_errc;

  always #5 clk = ~clk;

  instr_encode_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_valid(err_valid), .err_code(err_code), .word_count(word_count), .full(full)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Encoding rules written as shifts and masks, legality as signed ranges
  function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] w, output int code);
    int s;
    logic [31:0] base;
    s    = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w    = 32'd0;
    code = 0;
    case (fmt)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      3'd1: begin
        w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
        code = (s < -2048 || s > 2047) ? 2 : 0;
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
        code = (s < -2048 || s > 2047) ? 2 : 0;
      end
      3'd3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8) |
            (((imm >> 11) & 32'h1) << 7);
        if (s % 2 != 0) code = 3;
        else code = (s < -4096 || s > 4094) ? 2 : 0;
      end
      3'd4: begin
        w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
        code = ((imm & 32'hFFF) != 0) ? 3 : 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(op);
        if (s % 2 != 0) code = 3;
        else code = (s < -(1 << 20) || s > (1 << 20) - 2) ? 2 : 0;
      end
      default: code = 1;
    endcase
  endfunction

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_func7 = f7; in_imm = imm;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we"},    32'(imem_we),    32'(m_we));
    chk({tag, ".errv"},  32'(err_valid),  32'(m_errv));
    chk({tag, ".addr"},  32'(imem_addr),  32'(m_addr));
    chk({tag, ".wdata"}, imem_wdata,      m_wdata);
    chk({tag, ".errc"},  32'(err_code),   32'(m_errc));
    chk({tag, ".count"}, 32'(word_count), 32'(m_cnt));
    chk({tag, ".full"},  32'(full),       32'(m_state == 2));
  endtask

  // One clock: drive valid/start with the current fields, predict, check after the edge
  task automatic cycle(input logic v, input logic st, input string tag);
    logic        exp_ready;
    logic [31:0] w;
    int          code;
    in_valid = v;
    start    = st;
    exp_ready = (m_state == 1) && !st;
    #1;
    chk({tag, ".ready"}, 32'(in_ready), 32'(exp_ready));
    ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, w, code);
    m_we   = 1'b0;
    m_errv = 1'b0;
    if (st) begin
      m_state = 1; m_ptr = 0; m_cnt = 0;
    end else if (v && exp_ready) begin
      if (code == 0) begin
        m_we = 1'b1; m_addr = m_ptr; m_wdata = w; m_cnt++;
        if (m_cnt == DEPTH) begin m_state = 2; m_ptr = 0; end
        else m_ptr++;
      end else begin
        m_errv = 1'b1; m_errc = code;
      end
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_state = 0; m_ptr = 0; m_cnt = 0; m_we = 1'b0; m_addr = 0;
    m_wdata = 32'd0; m_errv = 1'b0; m_errc = 0;
    check_outputs(tag);
    chk({tag, ".ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(posedge clk); #1;
    do_reset("reset");

    // Basic I-type word
    cycle(1'b0, 1'b1, "start0");
    set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    cycle(1'b1, 1'b0, "addi");
    chk("addi.lit", imem_wdata, 32'h0050_0093);

    // Back-to-back S then B
    cycle(1'b0, 1'b1, "start1");
    set_fields(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    cycle(1'b1, 1'b0, "sw");
    chk("sw.lit", imem_wdata, 32'h0020_A423);
    set_fields(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    cycle(1'b1, 1'b0, "beq");
    chk("beq.lit", imem_wdata, 32'hFE00_0EE3);
    chk("beq.addr", 32'(imem_addr), 32'd1);

    // J and U
    cycle(1'b0, 1'b1, "start2");
    set_fields(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    cycle(1'b1, 1'b0, "jal");
    chk("jal.lit", imem_wdata, 32'h0010_00EF);
    set_fields(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    cycle(1'b1, 1'b0, "lui");
    chk("lui.lit", imem_wdata, 32'h1234_52B7);

    // Rejections: no write, pointer held
    cycle(1'b0, 1'b1, "start3");
    set_fields(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    cycle(1'b1, 1'b0, "b_misalign");
    chk("b_misalign.code", 32'(err_code), 32'd3);
    set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    cycle(1'b1, 1'b0, "i_range");
    chk("i_range.code", 32'(err_code), 32'd2);
    set_fields(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    cycle(1'b1, 1'b0, "bad_fmt");
    chk("bad_fmt.code", 32'(err_code), 32'd1);
    chk("bad_fmt.count", 32'(word_count), 32'd0);

    // Fill the region
    for (int i = 0; i < 4; i++) begin
      set_fields(3'd1, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3));
      cycle(1'b1, 1'b0, "fill");
      chk("fill.addr", 32'(imem_addr), 32'(i));
    end
    chk("full.flag", 32'(full), 32'd1);
    chk("full.ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b0, "fifth_ignored");
    chk("fifth.we", 32'(imem_we), 32'd0);
    cycle(1'b0, 1'b1, "restart");
    cycle(1'b1, 1'b0, "after_restart");
    chk("after_restart.addr", 32'(imem_addr), 32'd0);

    // start with in_valid: start wins
    cycle(1'b1, 1'b1, "start_vs_valid");
    chk("start_vs_valid.we", 32'(imem_we), 32'd0);

    // Accept followed by start: write still issues, count cleared
    cycle(1'b1, 1'b0, "pre_start");
    cycle(1'b0, 1'b1, "start_after_accept");
    chk("start_after_accept.count", 32'(word_count), 32'd0);

    // Accept followed by reset
    cycle(1'b1, 1'b0, "pre_rst");
    do_reset("rst_after_accept");
    chk("rst_after_accept.count", 32'(word_count), 32'd0);

    // Random bundles
    cycle(1'b0, 1'b1, "rstart");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2: imm = 32'($urandom_range(0, 3000000)) - 32'd1500000;
        default: imm = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) == 0);
      endcase
      set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), imm);
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
      else cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
